// File: rtl/periph_shell.sv
// Lycan peripheral slot shell: address-filtered TX/RX first-word-fall-through FIFOs around the core.
// Latency 1 cycle push-to-head; backpressure via bus_tx_full/core_rx_full, excess TX packets dropped and counted.
module periph_fifo #(
  parameter int DEPTH       = 16,
  parameter int WIDTH       = 29,
  parameter int AFULL_LEVEL = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty,
  output logic             full,
  output logic             afull
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_CNT = (AW+1)'(AFULL_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Full/empty come from pre-edge state, so a push into a full FIFO is refused even alongside a pop.
  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign afull    = (count >= AFULL_CNT);
  assign head_dat = mem[rd_ptr];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end
endmodule

// Slot top: matches/strips the slot address on TX, stamps it on RX, gates access until the ready window ends.
// Latency 1 cycle through either FIFO; drops on TX are counted saturating, RX overflow is discarded silently.
module periph_shell #(
  parameter int                    ADDR_WIDTH     = 3,
  parameter logic [ADDR_WIDTH-1:0] ADDRESS        = '0,
  parameter int                    PACKET_WIDTH   = 32,
  parameter int                    TX_DEPTH       = 16,
  parameter int                    RX_DEPTH       = 16,
  parameter int                    RX_AFULL_LEVEL = 12,
  parameter int                    READY_CYCLES   = 63
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PACKET_WIDTH-1:0]        bus_tx_data,
  input  logic                           bus_tx_valid,
  output logic                           bus_tx_full,
  output logic [PACKET_WIDTH-1:0]        bus_rx_data,
  input  logic                           bus_rx_read,
  output logic                           bus_rx_empty,
  output logic                           bus_rx_almost_full,
  output logic                           bus_rx_full,
  output logic [PACKET_WIDTH-ADDR_WIDTH-1:0] core_tx_data,
  output logic                           core_tx_valid,
  input  logic                           core_tx_read,
  input  logic [PACKET_WIDTH-ADDR_WIDTH-1:0] core_rx_data,
  input  logic                           core_rx_valid,
  output logic                           core_rx_full,
  input  logic                           flush,
  output logic [15:0]                    drop_count,
  output logic                           ready
);
  localparam int PAYLOAD_W = PACKET_WIDTH - ADDR_WIDTH;
  localparam int RW        = $clog2(READY_CYCLES + 1);
  localparam logic [RW-1:0] RDY_MAX = RW'(READY_CYCLES);

  logic [RW-1:0]        ready_cnt;
  logic                 tx_match;
  logic                 tx_drop;
  logic                 tx_full;
  logic                 tx_empty;
  logic                 tx_afull;
  logic                 rx_empty;
  logic                 rx_full;
  logic                 rx_afull;
  logic [PAYLOAD_W-1:0] rx_head_dat;

  assign ready    = (ready_cnt == RDY_MAX);
  assign tx_match = bus_tx_valid && (bus_tx_data[PACKET_WIDTH-1 -: ADDR_WIDTH] == ADDRESS);
  assign tx_drop  = tx_match && (tx_full || !ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_cnt <= '0;
    else if (!ready) ready_cnt <= ready_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_count <= '0;
    else if (tx_drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
  end

  periph_fifo #(
    .DEPTH       (TX_DEPTH),
    .WIDTH       (PAYLOAD_W),
    .AFULL_LEVEL (TX_DEPTH)
  ) u_tx_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (tx_match && ready),
    .push_dat (bus_tx_data[PAYLOAD_W-1:0]),
    .pop      (core_tx_read && core_tx_valid),
    .head_dat (core_tx_data),
    .empty    (tx_empty),
    .full     (tx_full),
    .afull    (tx_afull)
  );

  periph_fifo #(
    .DEPTH       (RX_DEPTH),
    .WIDTH       (PAYLOAD_W),
    .AFULL_LEVEL (RX_AFULL_LEVEL)
  ) u_rx_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (core_rx_valid && ready),
    .push_dat (core_rx_data),
    .pop      (bus_rx_read),
    .head_dat (rx_head_dat),
    .empty    (rx_empty),
    .full     (rx_full),
    .afull    (rx_afull)
  );

  // TX almost-full is never exported; it is tied into the full flag path only to keep the port used.
  assign bus_tx_full        = (tx_full && tx_afull) || !ready;
  assign core_tx_valid      = !tx_empty && ready;
  assign core_rx_full       = rx_full || !ready;
  assign bus_rx_empty       = rx_empty;
  assign bus_rx_full        = rx_full;
  assign bus_rx_almost_full = rx_afull;
  assign bus_rx_data        = {ADDRESS, rx_head_dat};
endmodule

// File: tb/tb_periph_shell.sv
// Bench for periph_shell with ADDRESS=5: vector table on the TX filter, scoreboard queues on both FIFOs.
module tb_periph_shell;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] bus_tx_data = '0;
  logic        bus_tx_valid = 1'b0;
  logic        bus_tx_full;
  logic [31:0] bus_rx_data;
  logic        bus_rx_read = 1'b0;
  logic        bus_rx_empty;
  logic        bus_rx_almost_full;
  logic        bus_rx_full;
  logic [28:0] core_tx_data;
  logic        core_tx_valid;
  logic        core_tx_read = 1'b0;
  logic [28:0] core_rx_data = '0;
  logic        core_rx_valid = 1'b0;
  logic        core_rx_full;
  logic        flush = 1'b0;
  logic [15:0] drop_count;
  logic        ready;

  periph_shell #(
    .ADDR_WIDTH (3),
    .ADDRESS    (3'd5)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .bus_tx_data        (bus_tx_data),
    .bus_tx_valid       (bus_tx_valid),
    .bus_tx_full        (bus_tx_full),
    .bus_rx_data        (bus_rx_data),
    .bus_rx_read        (bus_rx_read),
    .bus_rx_empty       (bus_rx_empty),
    .bus_rx_almost_full (bus_rx_almost_full),
    .bus_rx_full        (bus_rx_full),
    .core_tx_data       (core_tx_data),
    .core_tx_valid      (core_tx_valid),
    .core_tx_read       (core_tx_read),
    .core_rx_data       (core_rx_data),
    .core_rx_valid      (core_rx_valid),
    .core_rx_full       (core_rx_full),
    .flush              (flush),
    .drop_count         (drop_count),
    .ready              (ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dat;
    logic        acc;
    logic [15:0] drop;
    logic        full;
  } tx_vec_t;

  tx_vec_t     tbl [19];
  logic [28:0] tx_q [$];
  logic [28:0] rx_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " flags"}, 32'({bus_tx_full, core_rx_full, bus_rx_empty, bus_rx_full,
                               bus_rx_almost_full, core_tx_valid, ready}), 32'b111_0000);
    check({tag, " drop"}, 32'(drop_count), 32'd0);
    check({tag, " rx_addr"}, 32'(bus_rx_data[31:29]), 32'd5);
  endtask

  task automatic drain_tx(input string tag, input int exp_n);
    int          n = 0;
    logic [28:0] exp;
    for (int j = 0; j < 40; j++) begin
      if (!core_tx_valid) break;
      exp = (tx_q.size() != 0) ? tx_q.pop_front() : 'x;
      check({tag, " tx data"}, 32'(core_tx_data), 32'(exp));
      core_tx_read = 1'b1;
      tick();
      n++;
    end
    core_tx_read = 1'b0;
    check({tag, " tx count"}, 32'(n), 32'(exp_n));
    check({tag, " tx left"}, 32'(tx_q.size()), 32'd0);
  endtask

  task automatic drain_rx(input string tag, input int exp_n);
    int          n = 0;
    logic [28:0] exp;
    for (int j = 0; j < 40; j++) begin
      if (bus_rx_empty) break;
      exp = (rx_q.size() != 0) ? rx_q.pop_front() : 'x;
      check({tag, " rx data"}, bus_rx_data, {3'b101, exp});
      bus_rx_read = 1'b1;
      tick();
      n++;
    end
    bus_rx_read = 1'b0;
    check({tag, " rx count"}, 32'(n), 32'(exp_n));
    check({tag, " rx left"}, 32'(rx_q.size()), 32'd0);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 16; i++)
      tbl[i] = '{32'hA000_0000 | 32'(i), 1'b1, 16'd0, (i == 15)};
    tbl[16] = '{32'hA000_0099, 1'b0, 16'd1, 1'b1};
    tbl[17] = '{32'h4000_0001, 1'b0, 16'd1, 1'b1};
    tbl[18] = '{32'h8000_0003, 1'b0, 16'd1, 1'b1};

    // Reset state, then the no-access window with a matching packet held every cycle.
    #1 rst = 1'b1;
    #1 check_reset("reset");
    tick();
    tick();
    rst = 1'b0;
    bus_tx_valid = 1'b1;
    bus_tx_data  = 32'hA000_0077;
    for (int i = 1; i <= 63; i++) begin
      tick();
      check($sformatf("win%0d ready", i), 32'(ready), 32'(i == 63));
      check($sformatf("win%0d full", i), 32'(bus_tx_full), 32'(i != 63));
      check($sformatf("win%0d drop", i), 32'(drop_count), 32'(i));
    end
    tick();
    bus_tx_valid = 1'b0;
    check("first push valid", 32'(core_tx_valid), 32'd1);
    check("first push data", 32'(core_tx_data), 32'h77);
    check("first push drop", 32'(drop_count), 32'd63);

    // Asynchronous reset mid-operation, then the window restarts.
    #2 rst = 1'b1;
    #1 check_reset("async rst1");
    tick();
    rst = 1'b0;
    cyc = 0;
    while (!ready && cyc < 100) begin
      tick();
      cyc++;
    end
    check("ready latency", 32'(cyc), 32'd63);
    check("rx open", 32'(core_rx_full), 32'd0);
    check("tx empty after rst", 32'(core_tx_valid), 32'd0);

    // Address filter vectors: 16 accepted, one dropped when full, two foreign addresses ignored.
    for (int i = 0; i < 19; i++) begin
      bus_tx_valid = 1'b1;
      bus_tx_data  = tbl[i].dat;
      if (tbl[i].acc) tx_q.push_back(tbl[i].dat[28:0]);
      tick();
      check($sformatf("vec%0d full", i), 32'(bus_tx_full), 32'(tbl[i].full));
      check($sformatf("vec%0d drop", i), 32'(drop_count), 32'(tbl[i].drop));
    end
    bus_tx_valid = 1'b0;
    drain_tx("vec", 16);

    // RX fill to full, almost-full threshold, then push+pop while full.
    for (int k = 1; k <= 16; k++) begin
      core_rx_valid = 1'b1;
      core_rx_data  = 29'(32'h100 + k);
      rx_q.push_back(29'(32'h100 + k));
      tick();
      check($sformatf("rx%0d afull", k), 32'(bus_rx_almost_full), 32'(k >= 12));
      check($sformatf("rx%0d full", k), 32'(bus_rx_full), 32'(k == 16));
      if (k == 1) check("rx stamp", bus_rx_data, {3'b101, 29'h101});
    end
    check("rx core full", 32'(core_rx_full), 32'd1);
    core_rx_data = 29'h0DEAD;
    bus_rx_read  = 1'b1;
    void'(rx_q.pop_front());
    tick();
    core_rx_valid = 1'b0;
    bus_rx_read   = 1'b0;
    check("full pp full", 32'(bus_rx_full), 32'd0);
    check("full pp afull", 32'(bus_rx_almost_full), 32'd1);
    drain_rx("full pp", 15);

    // Continuous push+pop on both FIFOs across pointer wrap.
    for (int j = 0; j < 3; j++) begin
      core_rx_valid = 1'b1;
      core_rx_data  = 29'(32'h300 + j);
      rx_q.push_back(29'(32'h300 + j));
      bus_tx_valid = (j < 2);
      bus_tx_data  = 32'hA000_0200 + 32'(j);
      if (j < 2) tx_q.push_back(29'(32'h200 + j));
      tick();
    end
    for (int j = 0; j < 40; j++) begin
      check($sformatf("pp%0d tx", j), 32'(core_tx_data), 32'(tx_q.pop_front()));
      check($sformatf("pp%0d rx", j), bus_rx_data, {3'b101, rx_q.pop_front()});
      bus_tx_valid  = 1'b1;
      bus_tx_data   = 32'hA000_0400 + 32'(j);
      tx_q.push_back(29'(32'h400 + j));
      core_tx_read  = 1'b1;
      core_rx_valid = 1'b1;
      core_rx_data  = 29'(32'h500 + j);
      rx_q.push_back(29'(32'h500 + j));
      bus_rx_read   = 1'b1;
      tick();
      check($sformatf("pp%0d occ", j), 32'({core_tx_valid, bus_rx_empty, bus_rx_almost_full}), 32'b100);
    end
    bus_tx_valid  = 1'b0;
    core_tx_read  = 1'b0;
    core_rx_valid = 1'b0;
    bus_rx_read   = 1'b0;
    drain_tx("pp", 2);
    drain_rx("pp", 3);

    // Flush with simultaneous pushes on both sides.
    for (int j = 0; j < 9; j++) begin
      core_rx_valid = 1'b1;
      core_rx_data  = 29'(32'h600 + j);
      bus_tx_valid  = (j < 7);
      bus_tx_data   = 32'hA000_0700 + 32'(j);
      tick();
    end
    check("pre flush", 32'({core_tx_valid, bus_rx_empty}), 32'b10);
    bus_tx_valid  = 1'b1;
    bus_tx_data   = 32'hA000_07FF;
    core_rx_valid = 1'b1;
    core_rx_data  = 29'h6FF;
    flush         = 1'b1;
    tick();
    flush         = 1'b0;
    bus_tx_valid  = 1'b0;
    core_rx_valid = 1'b0;
    check("flush flags", 32'({core_tx_valid, bus_rx_empty, bus_tx_full, bus_rx_almost_full}), 32'b0100);
    check("flush drop", 32'(drop_count), 32'd1);
    tick();
    check("flush stays empty", 32'({core_tx_valid, bus_rx_empty}), 32'b01);
    bus_tx_valid = 1'b1;
    bus_tx_data  = 32'hA000_003C;
    tx_q.push_back(29'h3C);
    tick();
    bus_tx_valid = 1'b0;
    drain_tx("post flush", 1);

    // Drop counter saturation, then asynchronous reset with traffic still applied.
    for (int k = 0; k < 16; k++) begin
      bus_tx_valid = 1'b1;
      bus_tx_data  = 32'hA000_0800 + 32'(k);
      tick();
    end
    bus_tx_data = 32'hA000_00FF;
    for (int k = 0; k < 65533; k++) tick();
    check("drop FFFE", 32'(drop_count), 32'h0000_FFFE);
    for (int k = 0; k < 70000 - 65533; k++) tick();
    check("drop sat", 32'(drop_count), 32'h0000_FFFF);
    #3 rst = 1'b1;
    #1 check_reset("async rst2");
    tick();
    rst = 1'b0;
    bus_tx_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
